// File: rtl/node_pkg.sv
// Shared classifier-tree node definitions, loader stream framing constants and error codes.
package node_pkg;

    localparam int MAX_RULES_PER_NODE    = 4;
    localparam int MAX_CHILDREN_PER_NODE = 8;

    localparam logic [1:0] NODE_TYPE_LEAF     = 2'd0;
    localparam logic [1:0] NODE_TYPE_INTERNAL = 2'd1;
    localparam logic [1:0] NODE_TYPE_HYBRID   = 2'd2;
    localparam logic [1:0] NODE_TYPE_RSVD     = 2'd3;

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] mask;
        logic [55:0]  action;
        logic [7:0]   weight;
    } rule_s;

    typedef struct packed {
        logic [1:0]                                node_type;
        logic [3:0]                                rule_count;
        logic [3:0]                                child_count;
        logic [25:0]                               node_id;
        rule_s [MAX_RULES_PER_NODE-1:0]            rules;
        logic [MAX_CHILDREN_PER_NODE-1:0][31:0]    children;
    } node_s;

    localparam int NODE_WORD_W    = 32;
    localparam int NODE_NUM_WORDS = ($bits(node_s) + NODE_WORD_W - 1) / NODE_WORD_W;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SHORT = 2'd1;
    localparam logic [1:0] ERR_LONG  = 2'd2;
    localparam logic [1:0] ERR_FIELD = 2'd3;

endpackage

// File: rtl/node_field_check.sv
// Combinational sanity check of a reassembled node: reserved type and count limits.
// No latency; the loader registers the outcome alongside its state.
module node_field_check
    import node_pkg::*;
(
    input  node_s      node_i,
    output logic       ok_o,
    output logic [1:0] code_o
);

    logic bad_type;
    logic bad_rules;
    logic bad_children;

    assign bad_type     = (node_i.node_type == NODE_TYPE_RSVD);
    assign bad_rules    = (32'(node_i.rule_count)  > MAX_RULES_PER_NODE);
    assign bad_children = (32'(node_i.child_count) > MAX_CHILDREN_PER_NODE);

    assign ok_o   = !(bad_type || bad_rules || bad_children);
    assign code_o = ok_o ? ERR_NONE : ERR_FIELD;

endmodule

// File: rtl/node_word_loader.sv
// Rebuilds node_s from an MSB-first word stream; node valid the cycle after the last word.
// Stalls input (ready low) while a node waits for the consumer; errors pulse one cycle.
module node_word_loader
    import node_pkg::*;
#(
    parameter int WORD_W    = NODE_WORD_W,
    parameter int NODE_W    = $bits(node_s),
    parameter int NUM_WORDS = (NODE_W + WORD_W - 1) / WORD_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid_in,
    input  logic              word_last_in,
    output logic              word_ready_out,
    output node_s             node_out,
    output logic              node_valid_out,
    input  logic              node_ready_in,
    output logic              err_out,
    output logic [1:0]        err_code_out,
    output logic [31:0]       node_count_out
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_FULL    = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [NODE_W-1:0] buf_q;
    logic [NODE_W-1:0] buf_d;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic [31:0]       count_q;
    logic              chk_ok;
    logic [1:0]        chk_code;

    // Pad bits fall off the top as the remaining words shift in.
    assign buf_d = NODE_W'({buf_q, word_in});

    node_field_check u_check (
        .node_i (node_s'(buf_d)),
        .ok_o   (chk_ok),
        .code_o (chk_code)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_COLLECT;
            idx_q      <= '0;
            buf_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            count_q    <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_COLLECT: begin
                    if (word_valid_in) begin
                        buf_q <= buf_d;
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (!word_last_in) begin
                                err_q      <= 1'b1;
                                err_code_q <= ERR_LONG;
                                state_q    <= ST_DRAIN;
                            end else if (chk_ok) begin
                                state_q <= ST_FULL;
                            end else begin
                                err_q      <= 1'b1;
                                err_code_q <= chk_code;
                            end
                        end else if (word_last_in) begin
                            idx_q      <= '0;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_SHORT;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (word_valid_in && word_last_in) begin
                        state_q <= ST_COLLECT;
                    end
                end
                ST_FULL: begin
                    if (node_ready_in) begin
                        count_q <= count_q + 32'd1;
                        state_q <= ST_COLLECT;
                    end
                end
                default: begin
                    state_q <= ST_COLLECT;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign word_ready_out = (state_q != ST_FULL);
    assign node_valid_out = (state_q == ST_FULL);
    assign node_out       = node_s'(buf_q);
    assign err_out        = err_q;
    assign err_code_out   = err_code_q;
    assign node_count_out = count_q;

endmodule

// File: tb/tb_node_word_loader.sv
// Directed bench for node_word_loader: clean, back-pressure, short, long, field and reset cases.
module tb_node_word_loader;
    import node_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] word_in;
    logic        word_valid_in;
    logic        word_last_in;
    logic        word_ready_out;
    node_s       node_out;
    logic        node_valid_out;
    logic        node_ready_in;
    logic        err_out;
    logic [1:0]  err_code_out;
    logic [31:0] node_count_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_count = 0;

    always #5 clk_in = ~clk_in;

    node_word_loader dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .word_in        (word_in),
        .word_valid_in  (word_valid_in),
        .word_last_in   (word_last_in),
        .word_ready_out (word_ready_out),
        .node_out       (node_out),
        .node_valid_out (node_valid_out),
        .node_ready_in  (node_ready_in),
        .err_out        (err_out),
        .err_code_out   (err_code_out),
        .node_count_out (node_count_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic node_s mk_node(input logic [1:0] t, input logic [3:0] rc,
                                      input logic [3:0] cc, input logic [31:0] seed);
        node_s n;
        n = '0;
        n.node_type   = t;
        n.rule_count  = rc;
        n.child_count = cc;
        n.node_id     = seed[25:0];
        for (int i = 0; i < MAX_RULES_PER_NODE; i++) begin
            n.rules[i].key    = {4{seed ^ 32'(i * 32'h1111_0001)}};
            n.rules[i].mask   = ~n.rules[i].key;
            n.rules[i].action = {seed[23:0], 32'(i + 1)};
            n.rules[i].weight = 8'(i + 16);
        end
        for (int j = 0; j < MAX_CHILDREN_PER_NODE; j++) begin
            n.children[j] = seed + 32'(j * 3);
        end
        return n;
    endfunction

    function automatic logic [31:0] word_of(input node_s n, input int k);
        logic [NODE_NUM_WORDS*NODE_WORD_W-1:0] f;
        f = '0;
        f[$bits(node_s)-1:0] = n;
        return f[(NODE_NUM_WORDS-1-k)*NODE_WORD_W +: NODE_WORD_W];
    endfunction

    // Called at a negedge; the word is taken on the following posedge.
    task automatic put_word(input logic [31:0] w, input logic last);
        word_in       = w;
        word_valid_in = 1'b1;
        word_last_in  = last;
        @(negedge clk_in);
        word_valid_in = 1'b0;
        word_last_in  = 1'b0;
    endtask

    task automatic send_words(input node_s n, input int count, input int last_at);
        for (int k = 0; k < count; k++) begin
            put_word((k < NODE_NUM_WORDS) ? word_of(n, k) : (32'hDEAD_0000 + 32'(k)), k == last_at);
        end
    endtask

    // Sends a full clean frame with ready high and checks delivery and the count.
    task automatic deliver(input string tag, input node_s n);
        send_words(n, NODE_NUM_WORDS, NODE_NUM_WORDS - 1);
        check({tag, "_valid"}, node_valid_out, 1'b1);
        check({tag, "_node"}, node_out == n, 1'b1);
        check({tag, "_err"}, err_out, 1'b0);
        @(negedge clk_in);
        exp_count++;
        check({tag, "_count"}, node_count_out, exp_count);
        check({tag, "_vdrop"}, node_valid_out, 1'b0);
    endtask

    node_s na, nb, nc, nbad;

    initial begin
        rst_in        = 1'b1;
        word_in       = '0;
        word_valid_in = 1'b0;
        word_last_in  = 1'b0;
        node_ready_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;

        check("rst_wrdy", word_ready_out, 1'b1);
        check("rst_nvld", node_valid_out, 1'b0);
        check("rst_err", err_out, 1'b0);
        check("rst_code", err_code_out, 2'd0);
        check("rst_cnt", node_count_out, 32'd0);
        check("rst_node", node_out === '0, 1'b1);

        // Clean frame: type 2, 3 rules, no children, rule 3 weight 7.
        na = mk_node(2'd2, 4'd3, 4'd0, 32'h1234_5678);
        na.rules[3].weight = 8'd7;
        send_words(na, NODE_NUM_WORDS, NODE_NUM_WORDS - 1);
        check("clean_valid", node_valid_out, 1'b1);
        check("clean_wrdy", word_ready_out, 1'b0);
        check("clean_type", node_out.node_type, 2'd2);
        check("clean_rc", node_out.rule_count, 4'd3);
        check("clean_cc", node_out.child_count, 4'd0);
        check("clean_w3", node_out.rules[3].weight, 8'd7);
        check("clean_node", node_out == na, 1'b1);
        @(negedge clk_in);
        exp_count++;
        check("clean_cnt", node_count_out, 32'd1);

        // Back-pressure: hold the node for 10 cycles while input keeps offering words.
        nb = mk_node(2'd1, 4'd4, 4'd8, 32'hCAFE_0042);
        nc = mk_node(2'd0, 4'd1, 4'd2, 32'h0BAD_F00D);
        node_ready_in = 1'b0;
        send_words(nb, NODE_NUM_WORDS, NODE_NUM_WORDS - 1);
        word_in       = word_of(nc, 0);
        word_valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", node_valid_out, 1'b1);
            check("bp_wrdy", word_ready_out, 1'b0);
            check("bp_stable", node_out == nb, 1'b1);
            @(negedge clk_in);
        end
        node_ready_in = 1'b1;
        @(negedge clk_in);
        exp_count++;
        check("bp_cnt", node_count_out, exp_count);
        check("bp_vdrop", node_valid_out, 1'b0);
        check("bp_wrdy_back", word_ready_out, 1'b1);
        deliver("bp_next", nc);

        // Short frame: last on word 20.
        send_words(nb, 20, 19);
        check("short_err", err_out, 1'b1);
        check("short_code", err_code_out, ERR_SHORT);
        check("short_nvld", node_valid_out, 1'b0);
        @(negedge clk_in);
        check("short_pulse", err_out, 1'b0);
        check("short_hold", err_code_out, ERR_SHORT);
        deliver("short_next", na);

        // Long frame: 53 words, error after word 50, rest drained silently.
        send_words(nc, NODE_NUM_WORDS, -1);
        check("long_err", err_out, 1'b1);
        check("long_code", err_code_out, ERR_LONG);
        check("long_nvld", node_valid_out, 1'b0);
        for (int k = 0; k < 3; k++) begin
            put_word(32'hFEED_0000 + 32'(k), k == 2);
            check("long_drain_err", err_out, 1'b0);
            check("long_drain_nvld", node_valid_out, 1'b0);
            check("long_drain_wrdy", word_ready_out, 1'b1);
        end
        deliver("long_next", nb);

        // Field errors: too many rules, then reserved type.
        nbad = mk_node(2'd1, 4'd5, 4'd0, 32'h5555_0001);
        send_words(nbad, NODE_NUM_WORDS, NODE_NUM_WORDS - 1);
        check("rc_err", err_out, 1'b1);
        check("rc_code", err_code_out, ERR_FIELD);
        check("rc_nvld", node_valid_out, 1'b0);
        @(negedge clk_in);
        check("rc_pulse", err_out, 1'b0);
        check("rc_nvld2", node_valid_out, 1'b0);
        nbad = mk_node(2'd3, 4'd1, 4'd1, 32'h3333_0003);
        send_words(nbad, NODE_NUM_WORDS, NODE_NUM_WORDS - 1);
        check("type_err", err_out, 1'b1);
        check("type_code", err_code_out, ERR_FIELD);
        check("type_nvld", node_valid_out, 1'b0);
        deliver("field_next", nc);

        // Reset mid-frame after word 30.
        send_words(na, 30, -1);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        exp_count = 0;
        check("mrst_wrdy", word_ready_out, 1'b1);
        check("mrst_nvld", node_valid_out, 1'b0);
        check("mrst_err", err_out, 1'b0);
        check("mrst_code", err_code_out, 2'd0);
        check("mrst_cnt", node_count_out, 32'd0);
        check("mrst_node", node_out === '0, 1'b1);
        deliver("mrst_next", na);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
